// File: rtl/io_pkg.sv
// Shared encodings for io_intr_arbiter: channel ids, direction codes,
// interrupt-mask bit positions, output-channel state, and the mapping
// between a pending-vector index and the {channel, dir} irq_src code.
package io_pkg;

    // Channel count the encodings below are written for
    localparam int IO_NCH  = 2;
    localparam int IO_NREQ = 2 * IO_NCH;

    // Channel identifiers
    localparam logic CH_GPIO = 1'b0;
    localparam logic CH_UART = 1'b1;

    // Direction codes used in irq_src[0]
    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    // IMSK / pend bit positions: bit 2c+1 = input of channel c, bit 2c = output
    localparam int IMSK_CH0_OUT = 0;
    localparam int IMSK_CH0_IN  = 1;
    localparam int IMSK_CH1_OUT = 2;
    localparam int IMSK_CH1_IN  = 3;

    // Per-channel output state; READY means the output buffer may be written
    typedef enum logic {
        OUT_READY = 1'b0,
        OUT_BUSY  = 1'b1
    } out_state_t;

    // {channel, dir} -> pend index (2*ch + dir)
    function automatic logic [1:0] src_to_idx(input logic ch, input logic dir);
        return {ch, dir};
    endfunction

    // pend index -> {channel, dir}
    function automatic logic [1:0] idx_to_src(input logic [1:0] idx);
        return {idx[1], idx[0]};
    endfunction

endpackage

// File: rtl/io_prio_arbiter.sv
// Picks one request out of N pending interrupt sources.
// With IO_RR_EN defined the search starts at ptr and wraps (round robin);
// otherwise the lowest request index wins and no pointer input exists.
module io_prio_arbiter
    import io_pkg::*;
#(
    parameter int N  = IO_NREQ,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
`ifdef IO_RR_EN
    input  logic [IW-1:0] ptr,
`endif
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

`ifdef IO_RR_EN
    logic [IW-1:0] cand;
`endif
    logic found;

    // First pending request in search order; N is a power of two so the
    // candidate index wraps naturally.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
`ifdef IO_RR_EN
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IW'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                idx       = cand;
                gnt[cand] = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                idx    = IW'(i);
                gnt[i] = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/io_intr_arbiter.sv
// Shares one INPR/OUTR I/O port between NCH peripheral channels
// (ch0 = GPIO, ch1 = UART): per-channel FGI/FGO buffers, IMSK/IEN gating
// and a registered interrupt request with {channel, dir} source code.
// Optional macro IO_RR_EN selects round-robin source arbitration;
// without it the lowest pending index wins.
//
// Handshake: a peripheral transfer happens on a cycle where valid and ready
// are both high. in_ready = ~fgi and out_valid = ~fgo, so a peripheral
// transfer and a CPU access can never hit the same flag in one cycle.
module io_intr_arbiter
    import io_pkg::*;
#(
    parameter int NCH = 2,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DW-1:0]     cpu_wdata,
    input  logic              cpu_sel_we,
    input  logic              cpu_imsk_we,
    input  logic              cpu_ion,
    input  logic              cpu_iof,
    input  logic              cpu_inp,
    input  logic              cpu_out,
    input  logic              intr_ack,
    output logic [DW-1:0]     cpu_inpr,
    output logic              cpu_skip_in,
    output logic              cpu_skip_out,
    output logic              io_sel,
    output logic              ien,
    output logic [2*NCH-1:0]  imsk,
    output logic [NCH-1:0]    fgi,
    output logic [NCH-1:0]    fgo,
    output logic              irq,
    output logic [1:0]        irq_src,
    output logic              ovr,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH*DW-1:0] in_data,
    output logic [NCH-1:0]    in_ready,
    output logic [NCH-1:0]    out_valid,
    output logic [NCH*DW-1:0] out_data,
    input  logic [NCH-1:0]    out_ready
);

    logic [DW-1:0]    inbuf  [NCH];
    logic [DW-1:0]    outbuf [NCH];
    out_state_t       ost_q  [NCH];
    out_state_t       ost_d  [NCH];
    logic [NCH-1:0]   sel_oh;
    logic [NCH-1:0]   inp_hit;
    logic [NCH-1:0]   out_hit;
    logic [2*NCH-1:0] pend;
    logic [2*NCH-1:0] win_gnt;
    logic [1:0]       win_idx;
    logic             win_any;

    assign sel_oh       = NCH'(1) << io_sel;
    assign inp_hit      = {NCH{cpu_inp}} & sel_oh;
    assign out_hit      = {NCH{cpu_out}} & sel_oh;
    assign cpu_inpr     = inbuf[io_sel];
    assign cpu_skip_in  = fgi[io_sel];
    assign cpu_skip_out = fgo[io_sel];
    assign in_ready     = ~fgi;
    assign out_valid    = ~fgo;
    assign win_any      = |win_gnt;

    // Output-channel state register
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (!reset_n) ost_q[c] <= OUT_READY;
            else          ost_q[c] <= ost_d[c];
        end
    end

    // Output-channel next state: OUT makes it busy, peripheral accept frees it
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            ost_d[c] = ost_q[c];
            case (ost_q[c])
                OUT_READY: if (out_hit[c])   ost_d[c] = OUT_BUSY;
                OUT_BUSY:  if (out_ready[c]) ost_d[c] = OUT_READY;
                default:                     ost_d[c] = OUT_READY;
            endcase
        end
    end

    // Output-channel outputs: FGO is the READY state
    always_comb begin
        fgo = '0;
        for (int c = 0; c < NCH; c++) fgo[c] = (ost_q[c] == OUT_READY);
    end

    // Buffers, input flags, select, mask and sticky access-error flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                inbuf[c]  <= '0;
                outbuf[c] <= '0;
            end
            fgi    <= '0;
            imsk   <= '0;
            io_sel <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            if (cpu_sel_we)  io_sel <= cpu_wdata[0];
            if (cpu_imsk_we) imsk   <= cpu_wdata[2*NCH-1:0];
            if ((cpu_inp && !cpu_skip_in) || (cpu_out && !cpu_skip_out))
                ovr <= 1'b1;
            for (int c = 0; c < NCH; c++) begin
                if (in_valid[c] && !fgi[c]) begin
                    inbuf[c] <= in_data[c*DW +: DW];
                    fgi[c]   <= 1'b1;
                end else if (inp_hit[c] && fgi[c]) begin
                    fgi[c]   <= 1'b0;
                end
                if (out_hit[c] && fgo[c]) outbuf[c] <= cpu_wdata;
            end
        end
    end

    // Pending sources and output data bus
    always_comb begin
        pend     = '0;
        out_data = '0;
        for (int c = 0; c < NCH; c++) begin
            pend[src_to_idx(c[0], DIR_IN)]  = fgi[c] & imsk[2*c+1];
            pend[src_to_idx(c[0], DIR_OUT)] = fgo[c] & imsk[2*c];
            out_data[c*DW +: DW]            = outbuf[c];
        end
    end

`ifdef IO_RR_EN
    logic [1:0] rr_ptr;

    // Round-robin pointer: next search starts just after the last winner
    always_ff @(posedge clk) begin
        if (!reset_n)                rr_ptr <= '0;
        else if (intr_ack && win_any) rr_ptr <= win_idx + 2'd1;
    end
`endif

    io_prio_arbiter #(.N(2*NCH)) u_arb (
        .req (pend),
`ifdef IO_RR_EN
        .ptr (rr_ptr),
`endif
        .gnt (win_gnt),
        .idx (win_idx)
    );

    // Interrupt enable, registered request and source latch at acknowledge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ien     <= 1'b0;
            irq     <= 1'b0;
            irq_src <= '0;
        end else begin
            irq <= ien & (|pend) & ~intr_ack;
            if (intr_ack)     ien <= 1'b0;
            else if (cpu_iof) ien <= 1'b0;
            else if (cpu_ion) ien <= 1'b1;
            if (intr_ack && win_any) irq_src <= idx_to_src(win_idx);
        end
    end

endmodule
